// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: mdop codes, FSM states and
// default latencies that the hazard unit reuses.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_BUSY = 1'b1;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // True for the ops that occupy the unit for multiple cycles.
  function automatic logic is_md(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide datapath producing a HI/LO pair.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] sext_a;
  logic [63:0] sext_b;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;

  assign sext_a = {{32{A[31]}}, A};
  assign sext_b = {{32{B[31]}}, B};
  assign prod_s = sext_a * sext_b;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Unsigned magnitudes; 0x80000000 maps to itself, which is the correct magnitude.
  assign abs_a = A[31] ? (~A + 32'd1) : A;
  assign abs_b = B[31] ? (~B + 32'd1) : B;

  always_comb begin
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;
    mag_q       = '0;
    mag_r       = '0;
    case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (B == 32'd0) begin
          div_by_zero = 1'b1;
        end else begin
          mag_q  = abs_a / abs_b;
          mag_r  = abs_a % abs_b;
          res_lo = (A[31] ^ B[31]) ? (~mag_q + 32'd1) : mag_q;
          res_hi = A[31] ? (~mag_r + 32'd1) : mag_r;
        end
      end
      MD_DIVU: begin
        if (B == 32'd0) begin
          div_by_zero = 1'b1;
        end else begin
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls dependent MD ops.
//   state  | meaning
//   S_IDLE | accepting MULT/DIV/MTHI/MTLO
//   S_BUSY | result pending, counting down to commit
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  logic          state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_dz;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          div_by_zero;

  mdu_arith u_arith (
    .A           (A),
    .B           (B),
    .op          (mdop),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            if (is_md(mdop)) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_dz <= div_by_zero;
              cnt     <= (mdop == MD_MULT || mdop == MD_MULTU) ? MULT_CNT : DIV_CNT;
              busy    <= 1'b1;
              state   <= S_BUSY;
            end else if (mdop == MD_MTHI) begin
              hi <= A;
            end else if (mdop == MD_MTLO) begin
              lo <= A;
            end
          end
        end
        S_BUSY: begin
          if (cancel) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == '0) begin
            // Divide by zero completes on schedule but leaves HI/LO untouched.
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latency, arithmetic results, MT ops, ignore/cancel/reset.
module tb_mdu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int passes;

  mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdop   (mdop),
    .A      (a),
    .B      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one MD op, count busy cycles (bounded), then check HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic        held;
    int          n;
    chk({tag, "_stall_rule"}, {31'd0, busy}, 32'd0);
    old_hi = hi;
    old_lo = lo;
    held   = 1'b1;
    n      = 0;
    start  = 1'b1;
    mdop   = op;
    a      = va;
    b      = vb;
    step();
    start = 1'b0;
    mdop  = 3'd0;
    while (busy && n < 100) begin
      n++;
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      step();
    end
    chk({tag, "_busy_cycles"}, n, lat);
    chk({tag, "_hold"}, {31'd0, held}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    total  = 0;
    passes = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mdop   = 3'd0;
    a      = '0;
    b      = '0;
    cancel = 1'b0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_op("mult", 3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run_op("div_signs", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

    // MTHI / MTLO
    start = 1'b1; mdop = 3'd5; a = 32'h1234;
    step();
    start = 1'b0;
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    start = 1'b1; mdop = 3'd6; a = 32'h5678;
    step();
    start = 1'b0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi_kept", hi, 32'h1234);

    run_op("div0", 3'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("divu0", 3'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678);

    // Reserved and NONE ops with start do nothing.
    start = 1'b1; mdop = 3'd7; a = 32'hFFFF; b = 32'h3;
    step();
    mdop = 3'd0;
    step();
    start = 1'b0;
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h1234);
    chk("rsvd_lo", lo, 32'h5678);

    // Start during busy is ignored.
    start = 1'b1; mdop = 3'd1; a = 32'd3; b = 32'd5;
    step();
    start = 1'b0;
    n = 1;
    step();
    n++;
    start = 1'b1; mdop = 3'd4; a = 32'd9; b = 32'd3;
    step();
    start = 1'b0; mdop = 3'd0;
    n++;
    while (busy && n < 100) begin
      step();
      if (busy) n++;
    end
    chk("ign_busy_cycles", n, 32'd5);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);

    // Cancel at busy cycle 3 of a DIV.
    start = 1'b1; mdop = 3'd3; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    step();
    step();
    chk("cancel_pre_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd15);

    // Cancel in IDLE wins over start.
    start = 1'b1; cancel = 1'b1; mdop = 3'd5; a = 32'hDEAD;
    step();
    mdop = 3'd1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    chk("cancel_idle_hi", hi, 32'd0);

    // Asynchronous reset mid-DIV.
    start = 1'b1; mdop = 3'd5; a = 32'hAAAA;
    step();
    start = 1'b1; mdop = 3'd3; a = 32'd20; b = 32'd3;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("rst_mid_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op("post_rst_mult", 3'd1, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Back-to-back: issue in the first cycle busy is low.
    run_op("b2b_first", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42);
    run_op("b2b_second", 3'd2, 32'h10000, 32'h10000, 5, 32'd1, 32'd0);
    run_op("mult_negneg", 3'd1, 32'hFFFFFFFD, 32'hFFFFFFFB, 5, 32'd0, 32'd15);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Receives the same forwarded A/B operands the ALU receives.
- Owns the HI/LO architectural registers and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises busy so the hazard unit stalls dependent MD instructions (including MFHI/MFLO) in ID.

Parameters:
- MULT_LAT, 5, cycles busy is held for MULT/MULTU (≥1).
- DIV_LAT, 10, cycles busy is held for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  issue the operation on mdop this cycle.
- mdop  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- A  input  32  operand rs (dividend / multiplicand / MT source).
- B  input  32  operand rt (divisor / multiplier).
- cancel  input  1  synchronous abort of the in-flight op (exception flush).
- busy  output  1  registered; high while an op is in flight.
- hi  output  32  current HI register value.
- lo  output  32  current LO register value.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed): hi=0, lo=0, busy=0, counter=0, FSM=IDLE, pending results cleared. Applies mid-operation; the in-flight op is lost.
- FSM states: IDLE and BUSY.
- IDLE, start=1, mdop in {1..4}, cancel=0, at edge k:
  - Compute the 64-bit result from the A/B values at edge k into pending_hi/pending_lo.
  - Load counter with LAT-1, where LAT is MULT_LAT or DIV_LAT.
  - busy=1 from edge k; go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==0: hi<=pending_hi, lo<=pending_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly LAT cycles, and the new hi/lo are visible in the same cycle busy falls.
- MTHI/MTLO in IDLE with start=1: hi (or lo) <= A at the next edge; busy stays 0.
- start while BUSY: ignored, with no effect on hi/lo or the counter. Upstream must stall on (busy | start&mdop in 1..4); the bench asserts this rule.
- mdop NONE or 7 with start=1: no effect.
- cancel=1:
  - In BUSY: at the next edge go to IDLE, busy=0, hi/lo unchanged.
  - In IDLE: suppresses any start in the same cycle; cancel wins over start.
- MULT: signed 32x32 to 64; HI = bits[63:32], LO = bits[31:0].
- MULTU: unsigned 32x32 to 64, same HI/LO split.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000, with no trap.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (B=0, DIV or DIVU): busy still held for DIV_LAT cycles; at completion hi/lo keep their previous values.
- hi/lo are read combinationally. During BUSY they show the old values; they must not be updated early.

Decomposition:
- Shared package holds:
  - mdop encodings (MD_NONE..MD_MTLO).
  - FSM state encodings (S_IDLE, S_BUSY).
  - Default latency constants, which the hazard unit also uses.
- One combinational sub-module, mdu_arith: inputs A, B, op; outputs res_hi, res_lo, div_by_zero.
- The mdu top holds the FSM, counter, pending registers, HI/LO and the cancel/reset logic.

Test Plan:
- MULT A=0xFFFFFFFF B=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7 B=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI A=0x1234, then MTLO A=0x5678 (each with busy staying 0), then DIV B=0 -> busy 10 cycles, then hi=0x1234 and lo=0x5678 unchanged.
- MULT started; at cycle 2 of busy, pulse start with DIVU A=9 B=3 -> ignored; MULT completes on schedule with its own result. Next run: cancel at cycle 3 of a DIV -> busy 0 at the next edge, hi/lo unchanged.
- start DIV; drop rst_n mid-cycle during busy cycle 4 -> busy=0, hi=0, lo=0 immediately without a clock edge. After release, a MULT 3*4 -> lo=12, hi=0 after 5 cycles.
- Back-to-back: MULT completes, and start MULTU in the very cycle busy is 0 -> accepted; busy rises at the next edge and stays high 5 cycles; the first result is visible in between.
